// File: rtl/ret_addr_stack.sv
// LIFO return-address stack feeding the PC next-address mux on call/return.
// Optional build macro RET_STACK_WRAP_EN: push on full overwrites the oldest entry.
module ret_addr_stack #(
  parameter int AW    = 10,
  parameter int DEPTH = 8,
  parameter int CW    = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic          pop,
  input  logic [AW-1:0] pc_in,
  input  logic          clr_err,
  output logic [AW-1:0] ret_addr,
  output logic          empty,
  output logic          full,
  output logic [CW-1:0] count,
  output logic          overflow,
  output logic          underflow
);

  localparam int SPW = $clog2(DEPTH);

  logic [AW-1:0]  mem_q [DEPTH];
  logic [SPW-1:0] sp_q, sp_d;
  logic [CW-1:0]  count_q, count_d;
  logic           ovf_q, ovf_d;
  logic           unf_q, unf_d;
  logic [SPW-1:0] top_idx_s;
  logic           wr_en_s;
  logic [SPW-1:0] wr_idx_s;
  logic           ovf_set_s;
  logic           unf_set_s;

  assign top_idx_s = sp_q - SPW'(1);
  assign empty     = (count_q == CW'(0));
  assign full      = (count_q == CW'(DEPTH));
  assign count     = count_q;
  assign overflow  = ovf_q;
  assign underflow = unf_q;
  assign ret_addr  = empty ? AW'(0) : mem_q[top_idx_s];

  // Next-state decode: push/pop/replace actions and sticky error events
  always_comb begin
    sp_d      = sp_q;
    count_d   = count_q;
    wr_en_s   = 1'b0;
    wr_idx_s  = sp_q;
    ovf_set_s = 1'b0;
    unf_set_s = 1'b0;
    if (push && !pop) begin
      if (!full) begin
        wr_en_s = 1'b1;
        sp_d    = sp_q + SPW'(1);
        count_d = count_q + CW'(1);
      end else begin
        ovf_set_s = 1'b1;
`ifdef RET_STACK_WRAP_EN
        wr_en_s   = 1'b1;
        sp_d      = sp_q + SPW'(1);
`else
        wr_en_s   = 1'b0;
`endif
      end
    end else if (pop && !push) begin
      if (!empty) begin
        sp_d    = sp_q - SPW'(1);
        count_d = count_q - CW'(1);
      end else begin
        unf_set_s = 1'b1;
      end
    end else if (push && pop) begin
      // Return-then-call: the old top was consumed this cycle, so overwrite it in place
      if (!empty) begin
        wr_en_s  = 1'b1;
        wr_idx_s = top_idx_s;
      end else begin
        unf_set_s = 1'b1;
      end
    end else begin
      sp_d    = sp_q;
      count_d = count_q;
    end

    if (ovf_set_s) begin
      ovf_d = 1'b1;
    end else if (clr_err) begin
      ovf_d = 1'b0;
    end else begin
      ovf_d = ovf_q;
    end

    if (unf_set_s) begin
      unf_d = 1'b1;
    end else if (clr_err) begin
      unf_d = 1'b0;
    end else begin
      unf_d = unf_q;
    end
  end

  // Control state: pointer, depth and sticky flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sp_q    <= SPW'(0);
      count_q <= CW'(0);
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
    end else begin
      sp_q    <= sp_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
    end
  end

  // Entry storage is deliberately left out of reset
  always_ff @(posedge clk) begin
    if (wr_en_s) begin
      mem_q[wr_idx_s] <= pc_in;
    end
  end

endmodule

// File: doc/ret_addr_stack.md
Name: ret_addr_stack

Overview:
- LIFO return-address stack for subroutine call and return in the single-cycle processor.
- Sits between the control unit and the PC next-address mux.
  - On a call, the control unit pulses `push` with the return address (PC+1).
  - On a return, it pulses `pop`; `ret_addr` feeds the PC mux as the jump target.
- Reports `empty`/`full`, current depth, and sticky overflow/underflow error flags.

Parameters:
- AW, 10, address width; matches the PC and the instruction jump field [15:6].
- DEPTH, 8, number of stack entries; power of 2, minimum 2.
- CW, 4, width of `count`; must satisfy 2^CW > DEPTH.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- push  in  1  store `pc_in` as the new top this cycle.
- pop  in  1  remove the top entry this cycle.
- pc_in  in  AW  return address to push.
- clr_err  in  1  synchronous clear of `overflow` and `underflow`.
- ret_addr  out  AW  current top entry (combinational read of the top); 0 when empty.
- empty  out  1  count == 0.
- full  out  1  count == DEPTH.
- count  out  CW  number of valid entries.
- overflow  out  1  sticky: a push was attempted while full.
- underflow  out  1  sticky: a pop was attempted while empty.

Behaviour:
- Reset (reset == 0, asynchronous): sp=0, count=0, overflow=0, underflow=0, empty=1, full=0, ret_addr=0. Entry storage is not cleared.
- Storage: DEPTH x AW register array; sp points at the next free slot.
  - Top entry is mem[sp-1] (mod DEPTH).
  - `ret_addr` = mem[sp-1] when count>0, else 0.
  - A pushed value is visible on `ret_addr` the cycle after the push edge.
- Pop timing: the control unit samples `ret_addr` in the same cycle it asserts `pop`. The PC loads that value at the same edge that removes the entry.
- Per-edge actions, priority as listed:
  - push & !pop & !full: mem[sp]<=pc_in; sp<=sp+1; count<=count+1.
  - push & !pop & full: no write, sp/count unchanged, overflow<=1.
  - pop & !push & !empty: sp<=sp-1; count<=count-1.
  - pop & !push & empty: no change, underflow<=1.
  - push & pop & !empty: replace top, mem[sp-1]<=pc_in. sp/count unchanged. `ret_addr` before the edge is the old top (return-then-call).
  - push & pop & empty: treated as pop-on-empty; underflow<=1, push discarded.
  - Neither asserted: hold.
- clr_err: clears both flags at the edge. If an error event occurs in the same cycle, the set wins.
- sp wraps modulo DEPTH (log2(DEPTH) bits). count saturates at DEPTH and never goes below 0.
- empty/full/count: combinational from registered count; no pipeline latency.
- Reset mid-operation: any in-flight push/pop is lost; the stack returns to empty immediately, no clock needed.

Optional Feature:
- Macro: RET_STACK_WRAP_EN.
- Defined: push on full overwrites the oldest entry.
  - mem[sp]<=pc_in; sp<=sp+1; count stays DEPTH.
  - overflow is still set, giving a circular most-recent-DEPTH history.
- Undefined: push on full is discarded, as specified in Behaviour.
- All other behaviour is identical in both builds.

Test Plan:
- Reset low, then release -> empty=1, full=0, count=0, ret_addr=0x000, overflow=0, underflow=0.
- Push 0x011, 0x022, 0x033 on consecutive cycles -> count=3, ret_addr=0x033. Three pops return 0x033, 0x022, 0x011 in order, then empty=1, ret_addr=0.
- Push 0x100..0x108 (9 pushes, DEPTH=8):
  - Macro undefined -> full=1, overflow=1, count=8, ret_addr=0x107; 8 pops yield 0x107..0x100.
  - Macro defined -> overflow=1, ret_addr=0x108; 8 pops yield 0x108..0x101.
- Pop on empty -> underflow=1, count=0. clr_err next cycle -> underflow=0. clr_err together with another empty pop -> underflow stays 1.
- Stack holds 0x020 then 0x030; assert push(pc_in=0x3FF) and pop together:
  - ret_addr=0x030 during that cycle.
  - After the edge: ret_addr=0x3FF, count=2.
  - Pop -> 0x3FF, then 0x020.
- Push 3 entries, drive reset low between edges -> count=0, empty=1 asynchronously. After release, a pop sets underflow=1.
